// File: rtl/core_mc.sv
// core_mc: multi-cycle 16-bit fetch/decode/execute core with a req/ready port
// to a unified instruction/data memory.
module core_mc #(
  parameter int          ADDR_W   = 24,
  parameter int          NUM_REGS = 16,
  parameter logic [23:0] RESET_PC = 24'h2800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  output logic              halted,
  output logic              illegal_op
);
  localparam int RW = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  localparam logic [5:0] OP_AND   = 6'b000000;
  localparam logic [5:0] OP_OR    = 6'b000001;
  localparam logic [5:0] OP_NOT   = 6'b000010;
  localparam logic [5:0] OP_XOR   = 6'b000011;
  localparam logic [5:0] OP_ADDU  = 6'b000100;
  localparam logic [5:0] OP_SUBU  = 6'b000110;
  localparam logic [5:0] OP_CMP   = 6'b000111;
  localparam logic [5:0] OP_JMP   = 6'b100000;
  localparam logic [5:0] OP_BEQ   = 6'b100001;
  localparam logic [5:0] OP_LOAD  = 6'b100100;
  localparam logic [5:0] OP_MOVI  = 6'b101000;
  localparam logic [5:0] OP_STORE = 6'b101100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_FETCH_IMM, S_EXEC, S_MEM, S_HALT
  } state_t;

  state_t            state_reg, state_next;
  logic              live_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [5:0]        op_reg;
  logic [RW-1:0]     rd_reg, rs_reg;
  logic [15:0]       imm_reg;
  logic              z_reg, c_reg;
  logic [15:0]       regs [NUM_REGS];

  logic        one_word, two_word, is_halt;
  logic [15:0] rd_val, rs_val, alu_res;
  logic [16:0] sum_w, diff_w;
  logic        alu_wr, flag_wr, alu_c;

  assign rd_val = regs[rd_reg];
  assign rs_val = regs[rs_reg];
  assign sum_w  = {1'b0, rd_val} + {1'b0, rs_val};
  assign diff_w = {1'b0, rd_val} - {1'b0, rs_val};
  assign halted = (state_reg == S_HALT);

  always_comb begin
    one_word = 1'b0;
    two_word = 1'b0;
    is_halt  = 1'b0;
    case (op_reg)
      OP_AND, OP_OR, OP_NOT, OP_XOR, OP_ADDU, OP_SUBU, OP_CMP: one_word = 1'b1;
      OP_JMP, OP_BEQ, OP_LOAD, OP_MOVI, OP_STORE:              two_word = 1'b1;
      OP_HALT:                                                 is_halt  = 1'b1;
      default: ;
    endcase
  end

  // Bit 16 of diff_w is the borrow out of the 16-bit subtraction.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_wr  = 1'b0;
    flag_wr = 1'b0;
    case (op_reg)
      OP_AND:  begin alu_res = rd_val & rs_val; alu_wr = 1'b1; end
      OP_OR:   begin alu_res = rd_val | rs_val; alu_wr = 1'b1; end
      OP_NOT:  begin alu_res = ~rs_val;         alu_wr = 1'b1; end
      OP_XOR:  begin alu_res = rd_val ^ rs_val; alu_wr = 1'b1; end
      OP_ADDU: begin
        alu_res = sum_w[15:0]; alu_c = sum_w[16]; alu_wr = 1'b1; flag_wr = 1'b1;
      end
      OP_SUBU: begin
        alu_res = diff_w[15:0]; alu_c = diff_w[16]; alu_wr = 1'b1; flag_wr = 1'b1;
      end
      OP_CMP:  begin alu_res = diff_w[15:0]; alu_c = diff_w[16]; flag_wr = 1'b1; end
      OP_MOVI: begin alu_res = imm_reg; alu_wr = 1'b1; end
      default: ;
    endcase
  end

  // live_reg holds the bus idle for the first cycle after reset so that the
  // reset state presents mem_req=0 and mem_addr=0 even though state is FETCH.
  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    illegal_op = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (live_reg) begin
          mem_req  = 1'b1;
          mem_addr = pc_reg;
          if (mem_ready) state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (one_word)      state_next = S_EXEC;
        else if (two_word) state_next = S_FETCH_IMM;
        else if (is_halt)  state_next = S_HALT;
        else begin
          illegal_op = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_FETCH_IMM: begin
        mem_req  = 1'b1;
        mem_addr = pc_reg;
        if (mem_ready) state_next = S_EXEC;
      end
      S_EXEC: begin
        state_next = (op_reg == OP_LOAD || op_reg == OP_STORE) ? S_MEM : S_FETCH;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_W'(imm_reg);
        if (op_reg == OP_STORE) begin
          mem_we    = 1'b1;
          mem_wdata = rd_val;
        end
        if (mem_ready) state_next = S_FETCH;
      end
      S_HALT: ;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_FETCH;
      live_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      live_reg  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg  <= PC_INIT;
      op_reg  <= '0;
      rd_reg  <= '0;
      rs_reg  <= '0;
      imm_reg <= '0;
      z_reg   <= 1'b0;
      c_reg   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (live_reg && mem_ready) begin
            op_reg <= mem_rdata[15:10];
            rd_reg <= mem_rdata[5 +: RW];
            rs_reg <= mem_rdata[0 +: RW];
            pc_reg <= pc_reg + PC_ONE;
          end
        end
        S_FETCH_IMM: begin
          if (mem_ready) begin
            imm_reg <= mem_rdata;
            pc_reg  <= pc_reg + PC_ONE;
          end
        end
        S_EXEC: begin
          if (alu_wr) regs[rd_reg] <= alu_res;
          if (flag_wr) begin
            z_reg <= (alu_res == 16'h0000);
            c_reg <= alu_c;
          end
          if (op_reg == OP_JMP || (op_reg == OP_BEQ && z_reg))
            pc_reg <= ADDR_W'(imm_reg);
        end
        S_MEM: begin
          if (mem_ready && op_reg == OP_LOAD) regs[rd_reg] <= mem_rdata;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_core_mc.sv
// Bench for core_mc: a wait-state memory model checks every bus transfer
// against a queue of expected transfers pushed alongside each program.
`timescale 1ns/1ps
module tb_core_mc;
  localparam logic [5:0] OP_AND   = 6'b000000;
  localparam logic [5:0] OP_OR    = 6'b000001;
  localparam logic [5:0] OP_NOT   = 6'b000010;
  localparam logic [5:0] OP_XOR   = 6'b000011;
  localparam logic [5:0] OP_ADDU  = 6'b000100;
  localparam logic [5:0] OP_SUBU  = 6'b000110;
  localparam logic [5:0] OP_CMP   = 6'b000111;
  localparam logic [5:0] OP_BEQ   = 6'b100001;
  localparam logic [5:0] OP_LOAD  = 6'b100100;
  localparam logic [5:0] OP_MOVI  = 6'b101000;
  localparam logic [5:0] OP_STORE = 6'b101100;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] OP_BAD   = 6'b010101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, halted, illegal_op;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;

  core_mc #(.ADDR_W(24), .NUM_REGS(16), .RESET_PC(24'h2800)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    logic        we;
    logic [15:0] data;
  } xfer_t;

  xfer_t       sb[$];
  xfer_t       e;
  logic [15:0] mem [logic [23:0]];
  int          start_at [int];
  logic        c_at [int];
  logic        z_at [int];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          wait_n = 0;
  bit          hold_writes = 1'b0;
  int          wcnt = 0;
  bit          busy = 1'b0;
  logic [23:0] cur_addr = '0;
  logic        cur_we = 1'b0;
  int          ill_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: ready rises after wait_n low cycles; each completed transfer is scored.
  always @(negedge clk) begin
    if (illegal_op === 1'b1) ill_cnt++;
    if (rst || mem_req !== 1'b1) begin
      mem_ready = 1'b0;
      wcnt = 0;
      busy = 1'b0;
    end else begin
      if (mem_ready) busy = 1'b0;
      mem_ready = 1'b0;
      if (!busy) begin
        busy = 1'b1;
        wcnt = 0;
        cur_addr = mem_addr;
        cur_we = mem_we;
        start_at[int'(mem_addr)] = cyc;
        c_at[int'(mem_addr)] = dut.c_reg;
        z_at[int'(mem_addr)] = dut.z_reg;
      end else begin
        n_cmp++;
        assert (mem_addr === cur_addr && mem_we === cur_we) else begin
          n_bad++;
          $error("FAIL hold_stable addr=%h we=%b expected addr=%h we=%b",
                 mem_addr, mem_we, cur_addr, cur_we);
        end
      end
      if (wcnt >= wait_n && !(mem_we && hold_writes)) begin
        mem_ready = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'h0000;
        $display("xfer cyc=%0d addr=%h we=%b data=%h", cyc, mem_addr, mem_we,
                 mem_we ? mem_wdata : mem_rdata);
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_bad++;
          $error("FAIL xfer_extra addr=%h we=%b expected no transfer", mem_addr, mem_we);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          n_cmp++;
          assert (mem_addr === e.addr && mem_we === e.we && (!e.we || mem_wdata === e.data))
          else begin
            n_bad++;
            $error("FAIL xfer addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                   mem_addr, mem_we, mem_wdata, e.addr, e.we, e.data);
          end
        end
      end else begin
        wcnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [5:0] op, input int rd, input int rs);
    return {op, 5'(rd), 5'(rs)};
  endfunction

  task automatic put(input int a, input logic [15:0] w);
    mem[24'(a)] = w;
  endtask

  task automatic exp_rd(input int a);
    xfer_t x;
    x.addr = 24'(a); x.we = 1'b0; x.data = 16'h0000;
    sb.push_back(x);
  endtask

  task automatic exp_rds(input int a, input int n);
    for (int i = 0; i < n; i++) exp_rd(a + i);
  endtask

  task automatic exp_wr(input int a, input logic [15:0] d);
    xfer_t x;
    x.addr = 24'(a); x.we = 1'b1; x.data = d;
    sb.push_back(x);
  endtask

  task automatic begin_test(input int wn);
    rst = 1'b1;
    @(negedge clk);
    mem.delete(); sb.delete(); start_at.delete(); c_at.delete(); z_at.delete();
    wait_n = wn;
    hold_writes = 1'b0;
  endtask

  task automatic go();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin @(negedge clk); n++; end
    check(tag, sb.size(), 0);
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (halted !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check(tag, halted, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int req_cnt;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal_op, 0);

    // Arithmetic: carry/borrow and Z-driven branch
    begin_test(0);
    put(24'h2800, ins(OP_MOVI, 1, 0));  put(24'h2801, 16'hFFFF);
    put(24'h2802, ins(OP_MOVI, 2, 0));  put(24'h2803, 16'h0001);
    put(24'h2804, ins(OP_ADDU, 1, 2));
    put(24'h2805, ins(OP_STORE, 1, 0)); put(24'h2806, 16'h0050);
    put(24'h2807, ins(OP_BEQ, 0, 0));   put(24'h2808, 16'h2900);
    put(24'h2900, ins(OP_SUBU, 1, 2));
    put(24'h2901, ins(OP_STORE, 1, 0)); put(24'h2902, 16'h0051);
    put(24'h2903, ins(OP_BEQ, 0, 0));   put(24'h2904, 16'h2A00);
    put(24'h2905, ins(OP_HALT, 0, 0));
    exp_rds(24'h2800, 7); exp_wr(24'h50, 16'h0000); exp_rds(24'h2807, 2);
    exp_rds(24'h2900, 3); exp_wr(24'h51, 16'hFFFF); exp_rds(24'h2903, 3);
    go();
    drain("arith_drain", 200);
    wait_halt("arith_halt");
    check("addu_c", c_at[24'h2805], 1);
    check("addu_z", z_at[24'h2805], 1);
    check("subu_c", c_at[24'h2901], 1);
    check("subu_z", z_at[24'h2901], 0);

    // Wait states: three ready-low cycles per request
    begin_test(3);
    put(24'h2800, ins(OP_MOVI, 3, 0));  put(24'h2801, 16'h1234);
    put(24'h2802, ins(OP_STORE, 3, 0)); put(24'h2803, 16'h0040);
    put(24'h2804, ins(OP_LOAD, 4, 0));  put(24'h2805, 16'h0040);
    put(24'h2806, ins(OP_STORE, 4, 0)); put(24'h2807, 16'h0041);
    put(24'h2808, ins(OP_HALT, 0, 0));
    exp_rds(24'h2800, 4); exp_wr(24'h40, 16'h1234); exp_rds(24'h2804, 2);
    exp_rd(24'h40); exp_rds(24'h2806, 2); exp_wr(24'h41, 16'h1234); exp_rd(24'h2808);
    go();
    drain("ws_drain", 400);
    wait_halt("ws_halt");
    check("ws_movi_cyc", start_at[24'h2802] - start_at[24'h2800], 10);
    check("ws_store_cyc", start_at[24'h2804] - start_at[24'h2802], 14);
    check("ws_load_cyc", start_at[24'h2806] - start_at[24'h2804], 14);

    // Logic ops, CMP/BEQ both ways, illegal opcode, zero-wait timing, HALT
    begin_test(0);
    ill_cnt = 0;
    put(24'h2800, ins(OP_MOVI, 5, 0));  put(24'h2801, 16'h00F0);
    put(24'h2802, ins(OP_MOVI, 6, 0));  put(24'h2803, 16'h0FF0);
    put(24'h2804, ins(OP_CMP, 5, 6));
    put(24'h2805, ins(OP_BEQ, 0, 0));   put(24'h2806, 16'h2900);
    put(24'h2807, ins(OP_BAD, 1, 1));
    put(24'h2808, ins(OP_AND, 6, 5));
    put(24'h2809, ins(OP_XOR, 5, 5));
    put(24'h280A, ins(OP_NOT, 7, 6));
    put(24'h280B, ins(OP_OR, 5, 6));
    put(24'h280C, ins(OP_STORE, 6, 0)); put(24'h280D, 16'h0060);
    put(24'h280E, ins(OP_STORE, 7, 0)); put(24'h280F, 16'h0061);
    put(24'h2810, ins(OP_STORE, 5, 0)); put(24'h2811, 16'h0062);
    put(24'h2812, ins(OP_CMP, 5, 6));
    put(24'h2813, ins(OP_BEQ, 0, 0));   put(24'h2814, 16'h2900);
    put(24'h2900, ins(OP_HALT, 0, 0));
    exp_rds(24'h2800, 14); exp_wr(24'h60, 16'h00F0);
    exp_rds(24'h280E, 2);  exp_wr(24'h61, 16'hFF0F);
    exp_rds(24'h2810, 2);  exp_wr(24'h62, 16'h00F0);
    exp_rds(24'h2812, 3);  exp_rd(24'h2900);
    go();
    drain("ops_drain", 300);
    wait_halt("ops_halt");
    check("cmp_ne_c", c_at[24'h2805], 1);
    check("cmp_ne_z", z_at[24'h2805], 0);
    check("cmp_eq_c", c_at[24'h2813], 0);
    check("cmp_eq_z", z_at[24'h2813], 1);
    check("illegal_pulses", ill_cnt, 1);
    check("illegal_cyc", start_at[24'h2808] - start_at[24'h2807], 2);
    check("movi_cyc", start_at[24'h2802] - start_at[24'h2800], 4);
    check("alu_cyc", start_at[24'h2809] - start_at[24'h2808], 3);
    check("store_cyc", start_at[24'h280E] - start_at[24'h280C], 5);
    req_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req !== 1'b0) req_cnt++;
    end
    check("halt_no_req", req_cnt, 0);
    check("halt_stays", halted, 1);

    // Reset asserted while a STORE is stalled
    begin_test(0);
    hold_writes = 1'b1;
    put(24'h2800, ins(OP_MOVI, 1, 0));  put(24'h2801, 16'hABCD);
    put(24'h2802, ins(OP_STORE, 1, 0)); put(24'h2803, 16'h0070);
    put(24'h2804, ins(OP_HALT, 0, 0));
    exp_rds(24'h2800, 4);
    go();
    n = 0;
    while (!(mem_req === 1'b1 && mem_we === 1'b1) && n < 100) begin @(negedge clk); n++; end
    check("rm_store_pending", mem_we, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rm_req_drop", mem_req, 0);
    check("rm_we_drop", mem_we, 0);
    check("rm_addr_zero", mem_addr, 0);
    check("rm_no_write", mem.exists(24'h70), 0);
    check("rm_sb_empty", sb.size(), 0);
    @(negedge clk);
    hold_writes = 1'b0;
    exp_rds(24'h2800, 4); exp_wr(24'h70, 16'hABCD); exp_rd(24'h2804);
    go();
    drain("rm_drain", 200);
    wait_halt("rm_halt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
